// File: rtl/dispatch_controller.sv
// Dispatches producer words to one of two destinations selected by a data bit,
// stalling while the chosen destination is full and dropping the word on timeout.
module dispatch_controller #(
  parameter int DATA_BITS = 32,
  parameter int DEST_BIT  = 31,
  parameter int TIMEOUT   = 255,
  parameter int CNT_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_req,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 ready,
  input  logic                 full1,
  input  logic                 full2,
  output logic                 selector,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 wr_en1,
  output logic                 wr_en2,
  output logic                 drop_err,
  output logic [CNT_BITS-1:0]  cnt1,
  output logic [CNT_BITS-1:0]  cnt2
);

  localparam int STALL_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [STALL_W-1:0] TIMEOUT_V = STALL_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE} state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 dest_q, dest_d;
  logic [STALL_W-1:0]   stall_q, stall_d;
  logic                 ready_q, ready_d;
  logic                 selector_q, selector_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 wr_en1_q, wr_en1_d;
  logic                 wr_en2_q, wr_en2_d;
  logic                 drop_err_q, drop_err_d;
  logic [CNT_BITS-1:0]  cnt1_q, cnt1_d;
  logic [CNT_BITS-1:0]  cnt2_q, cnt2_d;
  logic                 dest_full;

  // Only the full flag of the latched destination matters.
  assign dest_full = dest_q ? full2 : full1;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    dest_d     = dest_q;
    stall_d    = stall_q;
    ready_d    = ready_q;
    selector_d = selector_q;
    data_out_d = data_out_q;
    wr_en1_d   = 1'b0;
    wr_en2_d   = 1'b0;
    drop_err_d = 1'b0;
    cnt1_d     = cnt1_q;
    cnt2_d     = cnt2_q;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          hold_d  = data_in;
          dest_d  = data_in[DEST_BIT];
          stall_d = '0;
          ready_d = 1'b0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!dest_full) begin
          selector_d = dest_q;
          data_out_d = hold_q;
          wr_en1_d   = ~dest_q;
          wr_en2_d   = dest_q;
          state_d    = ISSUE;
        end else if (stall_q == TIMEOUT_V) begin
          drop_err_d = 1'b1;
          ready_d    = 1'b1;
          state_d    = IDLE;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      ISSUE: begin
        // Counters advance as the strobe cycle completes.
        if (wr_en1_q) cnt1_d = cnt1_q + 1'b1;
        if (wr_en2_q) cnt2_d = cnt2_q + 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      dest_q     <= 1'b0;
      stall_q    <= '0;
      ready_q    <= 1'b1;
      selector_q <= 1'b0;
      data_out_q <= '0;
      wr_en1_q   <= 1'b0;
      wr_en2_q   <= 1'b0;
      drop_err_q <= 1'b0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      dest_q     <= dest_d;
      stall_q    <= stall_d;
      ready_q    <= ready_d;
      selector_q <= selector_d;
      data_out_q <= data_out_d;
      wr_en1_q   <= wr_en1_d;
      wr_en2_q   <= wr_en2_d;
      drop_err_q <= drop_err_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
    end
  end

  assign ready    = ready_q;
  assign selector = selector_q;
  assign data_out = data_out_q;
  assign wr_en1   = wr_en1_q;
  assign wr_en2   = wr_en2_q;
  assign drop_err = drop_err_q;
  assign cnt1     = cnt1_q;
  assign cnt2     = cnt2_q;

endmodule

// File: tb/tb_dispatch_controller.sv
// Bench for dispatch_controller: two instances (long timeout / 16-bit counters and
// short timeout / 2-bit counters) share stimulus and are checked against a transaction model.
module tb_dispatch_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req = 1'b0;
  logic [31:0] data_in = '0;
  logic        full1 = 1'b0;
  logic        full2 = 1'b0;

  logic        r0, s0, w10, w20, e0;
  logic [31:0] d0;
  logic [15:0] c10, c20;
  logic        r1, s1, w11, w21, e1;
  logic [31:0] d1;
  logic [1:0]  c11, c21;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dispatch_controller #(.DATA_BITS(32), .DEST_BIT(31), .TIMEOUT(255), .CNT_BITS(16)) dut0 (
    .clk(clk), .reset(reset), .wr_req(wr_req), .data_in(data_in), .ready(r0),
    .full1(full1), .full2(full2), .selector(s0), .data_out(d0), .wr_en1(w10),
    .wr_en2(w20), .drop_err(e0), .cnt1(c10), .cnt2(c20));

  dispatch_controller #(.DATA_BITS(32), .DEST_BIT(31), .TIMEOUT(3), .CNT_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .wr_req(wr_req), .data_in(data_in), .ready(r1),
    .full1(full1), .full2(full2), .selector(s1), .data_out(d1), .wr_en1(w11),
    .wr_en2(w21), .drop_err(e1), .cnt1(c11), .cnt2(c21));

  // Transaction model: one word in flight, described by whether it is waiting
  // for room, how long it has waited, and whether its write is being strobed.
  int          to_lim[2]  = '{255, 3};
  int          cnt_mod[2] = '{65536, 4};
  bit          busy[2], writing[2], held_dest[2];
  int          waited[2];
  logic [31:0] held_word[2];
  bit          x_ready[2], x_sel[2], x_w1[2], x_w2[2], x_drop[2];
  logic [31:0] x_dout[2];
  int          x_c1[2], x_c2[2];
  bit          model_valid = 1'b0;

  task automatic model_step(input int k);
    bit blocked;
    if (reset) begin
      busy[k] = 0; writing[k] = 0; waited[k] = 0;
      x_ready[k] = 1; x_sel[k] = 0; x_dout[k] = 0;
      x_w1[k] = 0; x_w2[k] = 0; x_drop[k] = 0; x_c1[k] = 0; x_c2[k] = 0;
    end else begin
      x_drop[k] = 0;
      if (writing[k]) begin
        if (held_dest[k]) x_c2[k] = (x_c2[k] + 1) % cnt_mod[k];
        else              x_c1[k] = (x_c1[k] + 1) % cnt_mod[k];
        writing[k] = 0; busy[k] = 0; x_ready[k] = 1;
        x_w1[k] = 0; x_w2[k] = 0;
      end else if (busy[k]) begin
        blocked = held_dest[k] ? full2 : full1;
        if (!blocked) begin
          writing[k] = 1;
          x_sel[k] = held_dest[k]; x_dout[k] = held_word[k];
          x_w1[k] = !held_dest[k]; x_w2[k] = held_dest[k];
        end else if (waited[k] == to_lim[k]) begin
          busy[k] = 0; x_drop[k] = 1; x_ready[k] = 1;
        end else begin
          waited[k]++;
        end
      end else if (wr_req) begin
        busy[k] = 1; waited[k] = 0; held_word[k] = data_in;
        held_dest[k] = data_in[31]; x_ready[k] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (reset) model_valid = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check("dut0.ready",    {31'b0, r0},  {31'b0, x_ready[0]});
      check("dut0.selector", {31'b0, s0},  {31'b0, x_sel[0]});
      check("dut0.data_out", d0,           x_dout[0]);
      check("dut0.wr_en1",   {31'b0, w10}, {31'b0, x_w1[0]});
      check("dut0.wr_en2",   {31'b0, w20}, {31'b0, x_w2[0]});
      check("dut0.drop_err", {31'b0, e0},  {31'b0, x_drop[0]});
      check("dut0.cnt1",     {16'b0, c10}, x_c1[0]);
      check("dut0.cnt2",     {16'b0, c20}, x_c2[0]);
      check("dut1.ready",    {31'b0, r1},  {31'b0, x_ready[1]});
      check("dut1.selector", {31'b0, s1},  {31'b0, x_sel[1]});
      check("dut1.data_out", d1,           x_dout[1]);
      check("dut1.wr_en1",   {31'b0, w11}, {31'b0, x_w1[1]});
      check("dut1.wr_en2",   {31'b0, w21}, {31'b0, x_w2[1]});
      check("dut1.drop_err", {31'b0, e1},  {31'b0, x_drop[1]});
      check("dut1.cnt1",     {30'b0, c11}, x_c1[1]);
      check("dut1.cnt2",     {30'b0, c21}, x_c2[1]);
    end
  end

  // Applies inputs for one cycle; outputs read right after belong to that cycle.
  task automatic cyc(input bit r, input bit w, input logic [31:0] d, input bit f1, input bit f2);
    @(negedge clk);
    reset = r; wr_req = w; data_in = d; full1 = f1; full2 = f2;
    $display("cycle t=%0t reset=%0b wr_req=%0b data_in=%08h full1=%0b full2=%0b",
             $time, r, w, d, f1, f2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("lit.reset_ready", {31'b0, r0}, 32'd1);
    check("lit.reset_dout",  d0, 32'd0);
    check("lit.reset_cnt1",  {16'b0, c10}, 32'd0);

    // Destination 1, not full.
    cyc(0, 1, 32'h0000_00A5, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("lit.a5_check_ready", {31'b0, r0}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    check("lit.a5_wr_en1", {31'b0, w10}, 32'd1);
    check("lit.a5_sel",    {31'b0, s0},  32'd0);
    check("lit.a5_dout",   d0, 32'h0000_00A5);
    cyc(0, 0, 0, 0, 0);
    check("lit.a5_cnt1",   {16'b0, c10}, 32'd1);
    check("lit.a5_wr_off", {31'b0, w10}, 32'd0);
    check("lit.a5_ready",  {31'b0, r0},  32'd1);

    // Destination 2, the other destination is full and must not matter.
    cyc(0, 1, 32'h8000_0001, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    check("lit.d2_wr_en2", {31'b0, w20}, 32'd1);
    check("lit.d2_wr_en1", {31'b0, w10}, 32'd0);
    check("lit.d2_sel",    {31'b0, s0},  32'd1);
    cyc(0, 0, 0, 1, 0);
    check("lit.d2_cnt2",   {16'b0, c20}, 32'd1);

    // Destination 2 full for 10 CHECK cycles; the short-timeout instance drops.
    cyc(0, 1, 32'h8000_0002, 1, 1);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 0, 0, 1, 1);
      check("lit.stall_drop1", {31'b0, e1}, {31'b0, (i == 5)});
    end
    cyc(0, 0, 0, 1, 0);
    check("lit.stall_no_wr", {31'b0, w20}, 32'd0);
    cyc(0, 0, 0, 1, 0);
    check("lit.stall_wr_en2", {31'b0, w20}, 32'd1);
    check("lit.stall_dropped_no_wr", {31'b0, w21}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    check("lit.stall_cnt2", {16'b0, c20}, 32'd2);

    // Destination 1 held full: short-timeout instance drops after 4 CHECK cycles.
    cyc(0, 1, 32'h0000_00A5, 1, 0);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 0, 0, (i <= 6), 0);
      check("lit.to_drop", {31'b0, e1}, {31'b0, (i == 5)});
      check("lit.to_no_wr", {31'b0, w11}, 32'd0);
      if (i == 5) check("lit.to_ready", {31'b0, r1}, 32'd1);
      if (i == 8) check("lit.long_wait_wr", {31'b0, w10}, 32'd1);
    end
    check("lit.long_wait_cnt1", {16'b0, c10}, 32'd2);

    // Reset during ISSUE.
    cyc(0, 1, 32'h0000_00A5, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("lit.issue_wr_before_reset", {31'b0, w10}, 32'd1);
    cyc(0, 0, 0, 0, 0);
    check("lit.rst_issue_wr1",  {31'b0, w10}, 32'd0);
    check("lit.rst_issue_cnt1", {16'b0, c10}, 32'd0);
    check("lit.rst_issue_cnt2", {16'b0, c20}, 32'd0);
    check("lit.rst_issue_ready", {31'b0, r0}, 32'd1);

    // Reset beats wr_req; reset during CHECK gives no drop and no strobe.
    cyc(1, 1, 32'h0000_00A5, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("lit.rst_wins_ready", {31'b0, r0}, 32'd1);
    cyc(0, 1, 32'h0000_0001, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    check("lit.rst_check_ready", {31'b0, r0}, 32'd1);
    check("lit.rst_check_drop",  {31'b0, e0}, 32'd0);
    cyc(0, 0, 0, 0, 0);
    check("lit.rst_check_wr", {31'b0, w10}, 32'd0);

    // Back-to-back writes to destination 1 with wr_req held; 2-bit counter wraps.
    for (int i = 0; i < 15; i++) cyc(0, 1, i, 0, 1);
    cyc(0, 0, 0, 0, 0);
    check("lit.wrap_cnt1_short", {30'b0, c11}, 32'd1);
    check("lit.wrap_cnt1_long",  {16'b0, c10}, 32'd5);
    check("lit.last_dout",       d0, 32'd12);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dispatch_controller.md
DISPATCH_CONTROLLER -- requirements
Module: dispatch_controller

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 32, meaning the width of the data word.
REQ-002 The block SHALL have parameter DEST_BIT, default 31, meaning the data_in bit index that selects the destination (0 = out1, 1 = out2).
REQ-003 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum stall cycles in CHECK before the word is dropped.
REQ-004 The block SHALL have parameter CNT_BITS, default 16, meaning the width of each per-destination dispatch counter.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 Port wr_req, input, 1 bit: the producer's request to hand over data_in.
REQ-008 Port data_in, input, DATA_BITS bits: the word to dispatch.
REQ-009 Port ready, output, 1 bit: high when the block accepts a word this cycle.
REQ-010 Port full1, input, 1 bit: destination 1 cannot accept a word.
REQ-011 Port full2, input, 1 bit: destination 2 cannot accept a word.
REQ-012 Port selector, output, 1 bit: drives the demultiplexer select input.
REQ-013 Port data_out, output, DATA_BITS bits: drives the demultiplexer data input.
REQ-014 Port wr_en1, output, 1 bit: write strobe to destination 1.
REQ-015 Port wr_en2, output, 1 bit: write strobe to destination 2.
REQ-016 Port drop_err, output, 1 bit: one-cycle pulse when a word is dropped on timeout.
REQ-017 Port cnt1, output, CNT_BITS bits: count of words written to destination 1.
REQ-018 Port cnt2, output, CNT_BITS bits: count of words written to destination 2.

Function
REQ-019 The FSM SHALL have exactly three states (IDLE, CHECK, ISSUE), and all outputs SHALL be registered.
REQ-020 ready SHALL be high only in IDLE.
REQ-021 In IDLE with wr_req=1, the block SHALL capture data_in into a hold register, latch dest = data_in[DEST_BIT], clear the stall counter and go to CHECK.
REQ-022 wr_req SHALL be ignored in CHECK and ISSUE: no capture, and the held word is not modified.
REQ-023 In CHECK, the block SHALL sample only the full flag of the latched destination.
REQ-024 In CHECK with that flag = 0, the block SHALL go to ISSUE on the next cycle.
REQ-025 In CHECK with that flag = 1, the block SHALL stay in CHECK and increment the stall counter.
REQ-026 In CHECK with that flag = 1 and the stall counter already = TIMEOUT, the block SHALL pulse drop_err for one cycle, discard the word and return to IDLE; no write strobe is issued.
REQ-027 On entering ISSUE, selector SHALL be set to dest and data_out to the held word.
REQ-028 In ISSUE, exactly one of wr_en1 or wr_en2 (per dest) SHALL be high for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-029 Full-flag changes during ISSUE SHALL be ignored.
REQ-030 selector and data_out SHALL hold their last ISSUE values outside ISSUE.
REQ-031 wr_en1 and wr_en2 SHALL never be high simultaneously and SHALL be 0 outside ISSUE.
REQ-032 Latency: with the destination not full, accept at cycle 0 gives CHECK at cycle 1, wr_en high during cycle 2, and ready high again at cycle 3; throughput is one word per 3 cycles.
REQ-033 cnt1 and cnt2 SHALL increment by 1 on each wr_en1 and wr_en2 cycle respectively, and SHALL wrap from 2^CNT_BITS-1 to 0.
REQ-034 The full flag of the non-selected destination SHALL have no effect.

Reset
REQ-035 With reset=1 at a clock edge, the FSM SHALL go to IDLE and all outputs SHALL reset as follows: ready=1 from the next cycle; selector=0; data_out=0; wr_en1=0; wr_en2=0; drop_err=0; cnt1=0; cnt2=0; stall counter=0.
REQ-036 Reset SHALL take priority over every other event, including wr_req in the same cycle.
REQ-037 Reset in CHECK or ISSUE SHALL discard the held word with no strobe and no drop_err pulse.

Verification
REQ-038 wr_req with data_in=0x0000_00A5, full1=0 -> selector=0, data_out=0x0000_00A5, wr_en1 high in cycle 2 only, cnt1=1.
REQ-039 wr_req with data_in=0x8000_0001, full2=0 -> selector=1, wr_en2 pulse in cycle 2, cnt2=1, wr_en1 stays 0.
REQ-040 data_in=0x8000_0002, full2=1 for 10 cycles then 0, full1=1 throughout -> 10 stall cycles, then a single wr_en2 pulse.
REQ-041 TIMEOUT=3, full1 held 1 -> drop_err pulses once after 4 CHECK cycles, no wr_en, ready returns 1.
REQ-042 Reset asserted in ISSUE -> wr_en1 and wr_en2 are 0 in the next cycle, counters are 0, state is IDLE.
REQ-043 CNT_BITS=2 with 5 writes to destination 1 -> cnt1 = 1.
